rc4_search_sequencer: RTL and testbench

RC4_SEARCH_SEQUENCER -- requirements
Module: rc4_search_sequencer

---
 rtl/rc4_search_sequencer.sv | 150 +++++++++++++++
 tb/tb_rc4_search_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rc4_search_sequencer.sv
// Key-search sequencer: walks keys KEY_FIRST..KEY_LAST through init/shuffle/read/decrypt sub-FSMs.
// Latency: one CLEAR cycle per key plus the four phase durations and one NEXT_KEY cycle; watchdog per phase.
// Backpressure: each phase start level is held until that phase's done flag; stop aborts any state to IDLE.
module rc4_search_sequencer #(
    parameter int unsigned            KEY_WIDTH      = 24,
    parameter logic [KEY_WIDTH-1:0]   KEY_FIRST      = '0,
    parameter logic [KEY_WIDTH-1:0]   KEY_LAST       = KEY_WIDTH'(24'h3FFFFF),
    parameter int unsigned            TIMEOUT_CYCLES = 4096
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 s_i_i_done,
    input  logic                 shuffle_done,
    input  logic                 s_read_done,
    input  logic                 decrypt_done,
    input  logic                 decrypt_valid,
    output logic                 start_s_i_i,
    output logic                 start_shuffle,
    output logic                 s_data_read_start,
    output logic                 start_decrypt,
    output logic                 reset_all,
    output logic [KEY_WIDTH-1:0] current_key,
    output logic [3:0]           current_state,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic                 timeout_err
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CLEAR     = 4'd1,
        ST_INIT      = 4'd2,
        ST_SHUFFLE   = 4'd3,
        ST_READ_S    = 4'd4,
        ST_DECRYPT   = 4'd5,
        ST_NEXT_KEY  = 4'd6,
        ST_FOUND     = 4'd7,
        ST_EXHAUSTED = 4'd8,
        ST_FAULT     = 4'd9
    } state_t;

    localparam int unsigned   WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    // Expiry is judged on the value the counter is about to reach, so FAULT
    // lands TIMEOUT_CYCLES-1 edges after phase entry.
    localparam logic [WD_W-1:0] WD_EXP = WD_W'(TIMEOUT_CYCLES - 2);

    state_t               state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
    logic                 terr_q, terr_d;

    logic phase_done;
    logic wd_expired;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            key_q   <= KEY_FIRST;
            wdog_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            wdog_q  <= wdog_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        terr_d     = terr_q;
        phase_done = 1'b0;
        wd_expired = (wdog_q == WD_EXP);

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    key_d   = KEY_FIRST;
                    terr_d  = 1'b0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_INIT;
            ST_INIT: begin
                phase_done = s_i_i_done;
                if (phase_done) state_d = ST_SHUFFLE;
            end
            ST_SHUFFLE: begin
                phase_done = shuffle_done;
                if (phase_done) state_d = ST_READ_S;
            end
            ST_READ_S: begin
                phase_done = s_read_done;
                if (phase_done) state_d = ST_DECRYPT;
            end
            ST_DECRYPT: begin
                phase_done = decrypt_done;
                if (phase_done) state_d = decrypt_valid ? ST_FOUND : ST_NEXT_KEY;
            end
            ST_NEXT_KEY: begin
                if (key_q == KEY_LAST) begin
                    state_d = ST_EXHAUSTED;
                end else begin
                    key_d   = key_q + KEY_WIDTH'(1);
                    state_d = ST_CLEAR;
                end
            end
            ST_FOUND, ST_EXHAUSTED, ST_FAULT: state_d = state_q;
            default: state_d = ST_IDLE;
        endcase

        // A done flag on the expiry cycle takes priority over the watchdog.
        if ((state_q == ST_INIT || state_q == ST_SHUFFLE ||
             state_q == ST_READ_S || state_q == ST_DECRYPT) &&
            !phase_done && wd_expired) begin
            state_d = ST_FAULT;
            terr_d  = 1'b1;
        end

        if (stop && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            key_d   = key_q;
            terr_d  = terr_q;
        end

        wdog_d = '0;
        if ((state_d == ST_INIT || state_d == ST_SHUFFLE ||
             state_d == ST_READ_S || state_d == ST_DECRYPT) &&
            state_d == state_q) begin
            wdog_d = wdog_q + WD_W'(1);
        end
    end

    assign start_s_i_i       = (state_q == ST_INIT);
    assign start_shuffle     = (state_q == ST_SHUFFLE);
    assign s_data_read_start = (state_q == ST_READ_S);
    assign start_decrypt     = (state_q == ST_DECRYPT);
    assign reset_all         = (state_q == ST_CLEAR);
    assign current_key       = key_q;
    assign current_state     = state_q;
    assign busy              = (state_q >= ST_CLEAR) && (state_q <= ST_NEXT_KEY);
    assign found             = (state_q == ST_FOUND);
    assign exhausted         = (state_q == ST_EXHAUSTED);
    assign timeout_err       = terr_q;

endmodule

// File: tb/tb_rc4_search_sequencer.sv
// Directed bench for rc4_search_sequencer: key walk to FOUND/EXHAUSTED, watchdog FAULT, stop and reset priority.
module tb_rc4_search_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, start, stop;
    logic        auto_en;
    logic        m_sii, m_shd, m_srd, m_dd, m_dv;
    logic        a_sii, a_shd, a_srd, a_dd;
    logic [23:0] valid_key;

    wire s_i_i_done    = auto_en ? a_sii : m_sii;
    wire shuffle_done  = auto_en ? a_shd : m_shd;
    wire s_read_done   = auto_en ? a_srd : m_srd;
    wire decrypt_done  = auto_en ? a_dd  : m_dd;
    wire decrypt_valid;

    logic        start_s_i_i, start_shuffle, s_data_read_start, start_decrypt, reset_all;
    logic [23:0] current_key;
    logic [3:0]  current_state;
    logic        busy, found, exhausted, timeout_err;

    assign decrypt_valid = auto_en ? (current_key == valid_key) : m_dv;

    int total, bad;
    int rst_cnt, dec_cnt, ph_cnt;
    int rst_base, dec_base;
    logic [3:0] prev_st;

    always #10 clk = ~clk;

    rc4_search_sequencer #(
        .KEY_WIDTH(24), .KEY_FIRST(24'd0), .KEY_LAST(24'd3), .TIMEOUT_CYCLES(16)
    ) dut (
        .CLOCK_50(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .s_i_i_done(s_i_i_done), .shuffle_done(shuffle_done),
        .s_read_done(s_read_done), .decrypt_done(decrypt_done),
        .decrypt_valid(decrypt_valid),
        .start_s_i_i(start_s_i_i), .start_shuffle(start_shuffle),
        .s_data_read_start(s_data_read_start), .start_decrypt(start_decrypt),
        .reset_all(reset_all), .current_key(current_key),
        .current_state(current_state), .busy(busy), .found(found),
        .exhausted(exhausted), .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] target, input int budget, input string tag);
        int n = 0;
        while (current_state !== target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {28'd0, current_state}, {28'd0, target});
    endtask

    // Sub-FSM model: each phase raises its done flag in its 5th cycle.
    initial begin
        a_sii = 0; a_shd = 0; a_srd = 0; a_dd = 0;
        rst_cnt = 0; dec_cnt = 0; ph_cnt = 0; prev_st = 4'd0;
        forever begin
            tick();
            if (reset_all === 1'b1) rst_cnt++;
            if (current_state == 4'd5 && prev_st != 4'd5) dec_cnt++;
            if (current_state == prev_st) ph_cnt++;
            else ph_cnt = 1;
            prev_st = current_state;
            a_sii = (current_state == 4'd2) && (ph_cnt == 5);
            a_shd = (current_state == 4'd3) && (ph_cnt == 5);
            a_srd = (current_state == 4'd4) && (ph_cnt == 5);
            a_dd  = (current_state == 4'd5) && (ph_cnt == 5);
        end
    end

    initial begin
        total = 0; bad = 0;
        reset_n = 0; start = 0; stop = 0; auto_en = 0;
        m_sii = 0; m_shd = 0; m_srd = 0; m_dd = 0; m_dv = 0;
        valid_key = 24'd2;

        #5;
        chk("rst_state", current_state, 0);
        chk("rst_key", current_key, 0);
        chk("rst_flags", {busy, found, exhausted, timeout_err, reset_all}, 0);
        chk("rst_starts", {start_s_i_i, start_shuffle, s_data_read_start, start_decrypt}, 0);
        #30 reset_n = 1;
        repeat (3) tick();
        chk("idle_hold", current_state, 0);

        // Search hits on key 2.
        auto_en = 1;
        rst_base = rst_cnt;
        start = 1; tick(); start = 0;
        chk("clear_state", current_state, 1);
        chk("clear_pulse", {reset_all, busy}, 2'b11);
        tick();
        chk("clear_one_cycle", {current_state, reset_all}, {4'd2, 1'b0});
        wait_state(4'd7, 400, "wait_found");
        chk("found_key", current_key, 2);
        chk("found_flags", {found, busy, exhausted}, 3'b100);
        chk("found_resets", rst_cnt - rst_base, 3);
        repeat (4) tick();
        chk("found_hold", current_state, 7);
        stop = 1; tick(); stop = 0;
        chk("found_stop", {current_state, found}, {4'd0, 1'b0});

        // No key passes: walk to EXHAUSTED.
        valid_key = 24'hFF;
        rst_base = rst_cnt;
        dec_base = dec_cnt;
        start = 1; tick(); start = 0;
        wait_state(4'd8, 400, "wait_exhausted");
        chk("exh_key", current_key, 3);
        chk("exh_flags", {exhausted, found, busy}, 3'b100);
        chk("exh_keys_tried", dec_cnt - dec_base, 4);
        repeat (10) tick();
        chk("exh_resets", rst_cnt - rst_base, 4);
        chk("exh_hold", current_state, 8);
        stop = 1; tick(); stop = 0;
        chk("exh_stop_key", {current_state, current_key}, {4'd0, 24'd3});
        auto_en = 0;

        // Watchdog FAULT in SHUFFLE; stray done flags and start while busy ignored.
        start = 1; tick(); tick();
        chk("init_state", current_state, 2);
        m_shd = 1; m_dd = 1; m_dv = 1; tick();
        chk("stray_done", {current_state, current_key}, {4'd2, 24'd0});
        start = 0; m_shd = 0; m_dd = 0; m_dv = 0;
        m_sii = 1; tick(); m_sii = 0;
        chk("shuffle_entry", current_state, 3);
        repeat (14) tick();
        chk("shuffle_pre_expiry", {current_state, timeout_err}, {4'd3, 1'b0});
        tick();
        chk("fault_state", {current_state, timeout_err, busy}, {4'd9, 1'b1, 1'b0});
        repeat (3) tick();
        chk("fault_hold", current_state, 9);
        stop = 1; tick(); stop = 0;
        chk("fault_stop_sticky", {current_state, timeout_err}, {4'd0, 1'b1});
        start = 1; tick(); start = 0;
        chk("restart_clears_err", {current_state, timeout_err}, {4'd1, 1'b0});

        // Done on the expiry cycle beats the watchdog.
        tick();
        m_sii = 1; tick(); m_sii = 0;
        repeat (14) tick();
        m_shd = 1; tick(); m_shd = 0;
        chk("expiry_done_wins", {current_state, timeout_err}, {4'd4, 1'b0});
        m_srd = 1; tick(); m_srd = 0;
        chk("decrypt_entry", current_state, 5);

        // stop overrides a valid decrypt result.
        stop = 1; m_dd = 1; m_dv = 1; tick();
        chk("stop_beats_found", {current_state, found}, {4'd0, 1'b0});
        stop = 0; m_dd = 0; m_dv = 0; tick();
        chk("stop_idle_hold", {current_state, found}, {4'd0, 1'b0});

        // Advance to key 1, then async reset inside SHUFFLE.
        start = 1; tick(); start = 0; tick();
        m_sii = 1; tick(); m_sii = 0;
        m_shd = 1; tick(); m_shd = 0;
        m_srd = 1; tick(); m_srd = 0;
        m_dd = 1; m_dv = 0; tick(); m_dd = 0;
        chk("next_key_state", current_state, 6);
        tick();
        chk("next_key_inc", {current_state, current_key}, {4'd1, 24'd1});
        tick();
        m_sii = 1; tick(); m_sii = 0;
        chk("key1_shuffle", current_state, 3);
        reset_n = 0; #1;
        chk("async_rst", {current_state, current_key}, {4'd0, 24'd0});
        chk("async_rst_flags", {busy, found, exhausted, timeout_err}, 0);
        #5 reset_n = 1;
        m_sii = 1; m_shd = 1; m_srd = 1; m_dd = 1;
        repeat (2) tick();
        chk("post_rst_idle", current_state, 0);
        m_sii = 0; m_shd = 0; m_srd = 0; m_dd = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
